// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
//   A packed value word (one hex nibble per digit) is captured into a pending
//   shadow register on 'load'. It is committed to the displayed (active)
//   register only at frame boundaries, so a frame never shows two different
//   words. Digits are scanned one at a time, and each digit stays lit for
//   REFRESH_DIV clocks. A digit is blanked when its per-digit mask bit is set,
//   or when it is a leading zero and lz_blank is set.
//
//   Optional build macro: SEVEN_SEGMENT_SCANNER_DIM_EN
//     Adds a 'brightness' input. The lit digit is enabled for brightness/16
//     of each slot. brightness is sampled at every frame boundary.
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   value       in   packed nibbles; digit 0 = value[3:0] (rightmost)
//   load        in   one-cycle strobe; captures value and blank_mask
//   blank_mask  in   1 = force that digit blank (captured with value)
//   lz_blank    in   1 = blank leading zeros (digit 0 excepted), live input
//   brightness  in   [DIM_EN only] 0..15 duty of each digit slot
//   seg         out  active-low segments {g,f,e,d,c,b,a}
//   an          out  active-low digit enables, one-hot-low
//   digit_idx   out  index of the digit currently being scanned
//   frame_tick  out  one-cycle pulse when digit_idx wraps to 0
module seven_segment_scanner #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = 16,
  localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_blank,
`ifdef SEVEN_SEGMENT_SCANNER_DIM_EN
  input  logic [3:0]              brightness,
`endif
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick
);

  // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] f_hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // ---------------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_presc;
  logic [IDX_W-1:0] r_digit_idx;
  logic             r_frame_tick;
  logic             w_presc_wrap;
  logic             w_idx_last;

  assign w_presc_wrap = (r_presc == CNT_W'(REFRESH_DIV - 1));
  assign w_idx_last   = (r_digit_idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_digit_idx  <= '0;
      r_frame_tick <= 1'b0;
    end else if (w_presc_wrap) begin
      r_presc      <= '0;
      r_digit_idx  <= w_idx_last ? '0 : r_digit_idx + IDX_W'(1);
      r_frame_tick <= w_idx_last;
    end else begin
      r_presc      <= r_presc + CNT_W'(1);
      r_frame_tick <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending / active value registers
  // ---------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] r_pend;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic [NUM_DIGITS-1:0]   r_pend_mask;
  logic [NUM_DIGITS-1:0]   r_active_mask;
  logic                    r_pend_valid;
  logic                    w_commit;
  logic [4*NUM_DIGITS-1:0] w_active_nxt;
  logic [NUM_DIGITS-1:0]   w_mask_nxt;

  assign w_commit = r_frame_tick & r_pend_valid;

  // The output register for digit 0 is loaded on the same edge as the commit.
  // So the decoder looks at the value the active register is about to take.
  // Otherwise digit 0 would briefly show the previous word.
  assign w_active_nxt = w_commit ? r_pend      : r_active;
  assign w_mask_nxt   = w_commit ? r_pend_mask : r_active_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend        <= '0;
      r_pend_mask   <= '0;
      r_pend_valid  <= 1'b0;
      r_active      <= '0;
      r_active_mask <= '0;
    end else begin
      r_active      <= w_active_nxt;
      r_active_mask <= w_mask_nxt;
      if (load) begin
        r_pend      <= value;
        r_pend_mask <= blank_mask;
      end
      // A load that coincides with a commit stays pending for the next frame.
      if (load)
        r_pend_valid <= 1'b1;
      else if (w_commit)
        r_pend_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit select, leading-zero detection and decode
  // ---------------------------------------------------------------------------
  logic [3:0]            w_nib;
  logic                  w_mask_bit;
  logic [NUM_DIGITS-1:0] w_upper_zero;  // bit i: nibbles i..NUM_DIGITS-1 all zero
  logic [NUM_DIGITS-1:0] w_an_onehot;
  logic                  w_blank;
  logic [6:0]            w_seg_dec;

  always_comb begin
    w_nib       = '0;
    w_mask_bit  = 1'b0;
    w_an_onehot = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_digit_idx == IDX_W'(i)) begin
        w_nib          = w_active_nxt[4*i +: 4];
        w_mask_bit     = w_mask_nxt[i];
        w_an_onehot[i] = 1'b0;
      end
    end
  end

  always_comb begin
    logic v_run;
    v_run        = 1'b1;
    w_upper_zero = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      v_run = v_run & (w_active_nxt[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      w_upper_zero[NUM_DIGITS-1-k] = v_run;
    end
  end

  always_comb begin
    logic v_upper_zero;
    v_upper_zero = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_digit_idx == IDX_W'(i))
        v_upper_zero = w_upper_zero[i];
    end
    w_blank   = w_mask_bit |
                (lz_blank & (r_digit_idx != '0) & v_upper_zero);
    w_seg_dec = w_blank ? SEG_BLANK : f_hex7(w_nib);
  end

  // ---------------------------------------------------------------------------
  // Slot enable (dimming)
  // ---------------------------------------------------------------------------
  logic w_slot_on;

`ifdef SEVEN_SEGMENT_SCANNER_DIM_EN
  logic [3:0] r_bright;
  logic [3:0] w_bright_nxt;

  // Same look-ahead as the value word, so that a new brightness applies to
  // the whole frame starting with digit 0.
  assign w_bright_nxt = r_frame_tick ? brightness : r_bright;
  assign w_slot_on    = (r_presc[CNT_W-1 -: 4] < w_bright_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_bright <= '0;
    else
      r_bright <= w_bright_nxt;
  end
`else
  assign w_slot_on = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
    end else begin
      r_seg <= w_slot_on ? w_seg_dec   : SEG_BLANK;
      r_an  <= w_slot_on ? w_an_onehot : '1;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign digit_idx  = r_digit_idx;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner
//   Directed bench for seven_segment_scanner with NUM_DIGITS=4, REFRESH_DIV=4.
//   Each frame lasts 16 clocks. run_frame walks the 16 negedges that follow a
//   frame start. It checks an/seg/digit_idx/frame_tick against hand-computed
//   values, and it can inject up to two loads at chosen cycles.
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic [3:0]  blank_mask;
  logic        lz_blank;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .load      (load),
    .blank_mask(blank_mask),
    .lz_blank  (lz_blank),
    .seg       (seg),
    .an        (an),
    .digit_idx (digit_idx),
    .frame_tick(frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected segments s0..s3 are listed for digit 0..3. A load is issued at
  // negedge k1 (and at k2) when that value is within 1..16.
  task automatic run_frame(input string name,
                           input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input int k1, input logic [15:0] v1, input logic [3:0] m1,
                           input int k2, input logic [15:0] v2, input logic [3:0] m2);
    logic [6:0] e_seg [4];
    logic [3:0] e_an;
    logic [1:0] e_idx;
    logic       e_tick;
    int         d;
    e_seg[0] = s0;
    e_seg[1] = s1;
    e_seg[2] = s2;
    e_seg[3] = s3;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      load   = 1'b0;
      d      = (k - 1) / 4;
      e_an   = 4'hF;
      e_an[d] = 1'b0;
      e_idx  = 2'((k / 4) % 4);
      e_tick = (k == 16);
      check($sformatf("%s an k%0d", name, k), 32'(an), 32'(e_an));
      check($sformatf("%s seg k%0d", name, k), 32'(seg), 32'(e_seg[d]));
      check($sformatf("%s idx k%0d", name, k), 32'(digit_idx), 32'(e_idx));
      check($sformatf("%s tick k%0d", name, k), 32'(frame_tick), 32'(e_tick));
      if (k == k1) begin
        value = v1; blank_mask = m1; load = 1'b1;
      end
      if (k == k2) begin
        value = v2; blank_mask = m2; load = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    value      = '0;
    load       = 1'b0;
    blank_mask = '0;
    lz_blank   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst an",   32'(an),         32'hF);
    check("rst seg",  32'(seg),        32'h7F);
    check("rst tick", 32'(frame_tick), 32'h0);
    check("rst idx",  32'(digit_idx),  32'h0);
    rst_n = 1'b1;

    // Frame 1: word 0. 12AF is loaded mid-frame but must not show yet.
    run_frame("f1", 7'h40, 7'h40, 7'h40, 7'h40, 3, 16'h12AF, 4'h0, 0, 16'h0, 4'h0);
    // Frame 2: 12AF. Two loads two cycles apart; the last one wins.
    run_frame("f2", 7'h0E, 7'h08, 7'h24, 7'h79, 2, 16'h1234, 4'h0, 4, 16'h5678, 4'h0);
    // Frame 3: 5678. Load 9999 with a mask. Load 0070 in the commit cycle.
    run_frame("f3", 7'h00, 7'h78, 7'h02, 7'h12, 6, 16'h9999, 4'b0101, 16, 16'h0070, 4'h0);
    // Frame 4: 9999 masked on digits 0 and 2. lz_blank has no effect here.
    lz_blank = 1'b1;
    run_frame("f4", 7'h7F, 7'h10, 7'h7F, 7'h10, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    // Frame 5: 0070 with leading-zero blanking.
    run_frame("f5", 7'h40, 7'h78, 7'h7F, 7'h7F, 8, 16'h0000, 4'h0, 0, 16'h0, 4'h0);
    // Frame 6: 0000 with leading-zero blanking; digit 0 still shows 0.
    run_frame("f6", 7'h40, 7'h7F, 7'h7F, 7'h7F, 3, 16'h12AF, 4'h0, 0, 16'h0, 4'h0);
    // Frame 7: 12AF becomes active again before the reset test.
    run_frame("f7", 7'h0E, 7'h08, 7'h24, 7'h79, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    lz_blank = 1'b0;

    // Assert reset mid-slot while digit 2 is lit.
    repeat (10) @(negedge clk);
    check("mid an before rst", 32'(an), 32'hB);
    rst_n = 1'b0;
    #1;
    check("mid rst an",   32'(an),         32'hF);
    check("mid rst seg",  32'(seg),        32'h7F);
    check("mid rst idx",  32'(digit_idx),  32'h0);
    check("mid rst tick", 32'(frame_tick), 32'h0);
    repeat (2) @(negedge clk);
    check("held rst an", 32'(an), 32'hF);
    rst_n = 1'b1;

    // After release: scan restarts at digit 0, and the active word is 0.
    run_frame("post", 7'h40, 7'h40, 7'h40, 7'h40, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Parametrised, time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits. Each digit is a 4-bit hex nibble.
- Captures a packed value word into a shadow register and commits it atomically at frame boundaries.
- Scans one digit at a time at a programmable refresh rate, with per-digit and leading-zero blanking.
- Sits between game/score logic and the board display pins; replaces per-digit static decoders.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8)
- REFRESH_DIV, 50000, clk cycles each digit stays lit (>=2)
- CNT_W, 16, prescaler width; must satisfy 2^CNT_W >= REFRESH_DIV

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- value  in  4*NUM_DIGITS  packed nibbles; digit 0 = value[3:0] = rightmost
- load  in  1  one-cycle strobe that captures value into the pending register
- blank_mask  in  NUM_DIGITS  1 = force digit blank; sampled together with value on load
- lz_blank  in  1  1 = blank leading zeros; digit 0 is never blanked by this rule
- seg  out  7  active-low segments {g,f,e,d,c,b,a}
- an  out  NUM_DIGITS  active-low digit enables, one-hot-low
- digit_idx  out  clog2(NUM_DIGITS) (min 1)  index of the lit digit
- frame_tick  out  1  one-cycle pulse when digit_idx wraps to 0

Behaviour:
- One clock domain, async active-low reset. Reset values:
  - prescaler, digit_idx: 0
  - an: all 1 (all digits off)
  - seg: 7'h7F
  - frame_tick: 0
  - pending, active and their masks: 0
  - pending_valid: 0
- Prescaler counts 0..REFRESH_DIV-1 and wraps. On wrap, digit_idx increments modulo NUM_DIGITS. When the increment lands on 0, frame_tick pulses for that cycle.
- load=1: the pending register takes value and blank_mask, and pending_valid sets. Back-to-back loads overwrite pending; the last one wins.
- Frame commit: in the cycle frame_tick is asserted, if pending_valid, the active registers take pending and pending_valid clears. A load in the same cycle as a commit goes to pending only and is committed at the next frame.
- Display never mixes two value words within a frame.
- Outputs are registered, so seg and an reflect digit_idx with 1 cycle latency. an drives exactly one bit low at all times after the first post-reset cycle.
- Decode (active-low hex, {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - blank = 7F
- Blank condition for digit i: active_mask[i]=1, OR (lz_blank=1 AND i>0 AND active nibbles i..NUM_DIGITS-1 all zero).
  - When blanked, seg=7F while an still strobes, which keeps per-digit duty constant.
- lz_blank is live (not shadowed); a change takes effect on the next digit slot.
- Reset mid-scan: immediate return to reset values; scanning restarts at digit 0 after release.
- NUM_DIGITS=1: digit_idx stays 0, frame_tick pulses every REFRESH_DIV cycles, an stays 0 after the first cycle.

Optional Feature:
- Macro: SEVEN_SEGMENT_SCANNER_DIM_EN
- When defined:
  - Adds input brightness[3:0].
  - Within each digit slot, an is active only while prescaler[CNT_W-1 -: 4] < brightness. Otherwise an is all 1 and seg=7F.
  - brightness=0 means always off; brightness=15 means active 15/16 of the slot.
  - brightness is sampled at frame commit.
- When undefined: no brightness port, and the digit is active for the full slot.

Test Plan:
- Reset, then release with REFRESH_DIV=4, NUM_DIGITS=4 -> an sequence E,D,B,7 with each held 4 cycles. frame_tick pulses once every 16 cycles. seg=40 on all digits (active value 0, lz_blank=0).
- load value=16'h12AF, mask 0 -> until the next frame_tick, seg stays at the old word. From the following frame: digit0=0E, digit1=08, digit2=24, digit3=79.
- load 16'h1234, then load 16'h5678 two cycles later, both within one frame -> only 5678 is displayed (digit0=00, digit3=12). 1234 never appears.
- value=16'h0070, lz_blank=1 -> digits 3,2 seg=7F; digit1=78; digit0=40. With value=0, digit0=40 and the others 7F.
- blank_mask=4'b0101, value=16'h9999 -> digits 0 and 2 show 7F, digits 1 and 3 show 10. an keeps strobing all four.
- Assert rst_n=0 mid-slot on digit 2 -> same cycle an=F and seg=7F. After release, digit 0 is lit first and the active word is 0.
